// File: rtl/serial_pkg.sv
// Shared definitions for the serial line receiver: the ASCII control codes
// it reacts to and the collect/hold state encoding.
package serial_pkg;

   localparam logic [7:0] ASCII_BS  = 8'h08;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_DEL = 8'h7F;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } rx_state_e;

   function automatic logic is_term(input logic [7:0] b);
      return (b == ASCII_CR) || (b == ASCII_LF);
   endfunction

   function automatic logic is_erase(input logic [7:0] b);
      return (b == ASCII_BS) || (b == ASCII_DEL);
   endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Line buffer storage: one synchronous write port and one registered read
// port with no reset, so it maps onto a block RAM.
module line_buf_ram #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [DEPTH];
   logic [7:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/serial_line_rx.sv
// Assembles bytes from the UART output stream into lines with backspace
// editing, then holds each completed line until the consumer acknowledges it.
module serial_line_rx
   import serial_pkg::*;
#(
   parameter int LINE_DEPTH = 32
) (
   input  logic                              clk_48mhz,
   input  logic                              reset_n,
   input  logic [7:0]                        uart_out_data,
   input  logic                              uart_out_valid,
   output logic                              uart_out_ready,
   output logic                              line_valid,
   output logic [$clog2(LINE_DEPTH+1)-1:0]   line_len,
   output logic                              line_ovf,
   input  logic [$clog2(LINE_DEPTH)-1:0]     rd_addr,
   output logic [7:0]                        rd_data,
   input  logic                              line_ack
);

   localparam int LEN_W  = $clog2(LINE_DEPTH + 1);
   localparam int ADDR_W = $clog2(LINE_DEPTH);
   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(LINE_DEPTH);

   rx_state_e        state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;
   logic             out_en_q, out_en_d;

   logic             accept;
   logic             wr_en;
   logic [7:0]       ram_rd_data;

   // out_en_q stays low through reset and rises on the first edge after it,
   // which both delays ready and masks the unreset RAM read register.
   assign out_en_d = 1'b1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      accept  = uart_out_valid && uart_out_ready;

      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               if (is_term(uart_out_data)) begin
                  if ((len_q != '0) || ovf_q) begin
                     state_d = ST_HOLD;
                  end
               end else if (is_erase(uart_out_data)) begin
                  if (len_q != '0) begin
                     len_d = len_q - LEN_W'(1);
                  end
               end else if (len_q < FULL_LEN) begin
                  wr_en = 1'b1;
                  len_d = len_q + LEN_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (line_ack) begin
               state_d = ST_COLLECT;
               len_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_COLLECT;
         len_q    <= '0;
         ovf_q    <= 1'b0;
         out_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         ovf_q    <= ovf_d;
         out_en_q <= out_en_d;
      end
   end

   line_buf_ram #(
      .DEPTH  (LINE_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_line_buf (
      .clk     (clk_48mhz),
      .wr_en   (wr_en),
      .wr_addr (len_q[ADDR_W-1:0]),
      .wr_data (uart_out_data),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

   assign uart_out_ready = out_en_q && (state_q == ST_COLLECT);
   assign line_valid     = (state_q == ST_HOLD);
   assign line_len       = len_q;
   assign line_ovf       = ovf_q;
   assign rd_data        = out_en_q ? ram_rd_data : 8'h00;

endmodule

// File: tb/tb_serial_line_rx.sv
// Directed and randomised-valid bench for serial_line_rx: line editing,
// overflow, back-to-back turnaround and reset while holding a line.
module tb_serial_line_rx;

   localparam int LINE_DEPTH = 32;

   logic       clk_48mhz = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] uart_out_data = 8'h00;
   logic       uart_out_valid = 1'b0;
   logic       uart_out_ready;
   logic       line_valid;
   logic [5:0] line_len;
   logic       line_ovf;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_data;
   logic       line_ack = 1'b0;

   int checks = 0;
   int failures = 0;

   serial_line_rx #(.LINE_DEPTH(LINE_DEPTH)) dut (
      .clk_48mhz      (clk_48mhz),
      .reset_n        (reset_n),
      .uart_out_data  (uart_out_data),
      .uart_out_valid (uart_out_valid),
      .uart_out_ready (uart_out_ready),
      .line_valid     (line_valid),
      .line_len       (line_len),
      .line_ovf       (line_ovf),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .line_ack       (line_ack)
   );

   always #10 clk_48mhz = ~clk_48mhz;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_48mhz);
      #1;
   endtask

   // Present b with valid high until accepted; valid is left high afterwards.
   task automatic send_byte(input logic [7:0] b, output int waits);
      logic r;
      uart_out_data  = b;
      uart_out_valid = 1'b1;
      waits = 0;
      forever begin
         r = uart_out_ready;
         tick();
         if (r) break;
         waits++;
         if (waits > 200) begin
            chk("send_ready_timeout", 32'(uart_out_ready), 32'd1);
            break;
         end
      end
   endtask

   task automatic send(input logic [7:0] b);
      int w;
      send_byte(b, w);
   endtask

   task automatic send_str(input string s);
      for (int k = 0; k < s.len(); k++) send(s[k]);
   endtask

   task automatic read_check(input string tag, input int addr, input logic [7:0] exp);
      rd_addr = 5'(addr);
      tick();
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic pulse_ack();
      line_ack = 1'b1;
      tick();
      line_ack = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(uart_out_ready), 32'd0);
      chk({tag, "_valid"}, 32'(line_valid), 32'd0);
      chk({tag, "_ovf"},   32'(line_ovf), 32'd0);
      chk({tag, "_len"},   32'(line_len), 32'd0);
      chk({tag, "_rdata"}, 32'(rd_data), 32'd0);
   endtask

   // Random-valid reference model state
   logic [7:0] mbuf [LINE_DEPTH];
   int         mlen;
   bit         movf;

   initial begin
      int w;
      int lines;
      logic [7:0] b;
      bit term;

      // Reset state
      tick();
      tick();
      chk_all_zero("rst");
      reset_n = 1'b1;
      #1;
      chk("rst_ready_before_edge", 32'(uart_out_ready), 32'd0);
      tick();
      chk("rst_ready_after_edge", 32'(uart_out_ready), 32'd1);

      // "AB\r\n" with valid held high
      send_str("AB");
      send(8'h0D);
      uart_out_data = 8'h0A;
      chk("t1_valid", 32'(line_valid), 32'd1);
      chk("t1_len", 32'(line_len), 32'd2);
      chk("t1_ovf", 32'(line_ovf), 32'd0);
      chk("t1_ready", 32'(uart_out_ready), 32'd0);
      read_check("t1_rd0", 0, 8'h41);
      read_check("t1_rd1", 1, 8'h42);
      repeat (3) tick();
      chk("t1_ready_hold", 32'(uart_out_ready), 32'd0);
      chk("t1_valid_hold", 32'(line_valid), 32'd1);
      pulse_ack();
      chk("t1_ready_after_ack", 32'(uart_out_ready), 32'd1);
      chk("t1_valid_after_ack", 32'(line_valid), 32'd0);
      repeat (3) tick();
      chk("t1_single_line", 32'(line_valid), 32'd0);
      chk("t1_len_after_lf", 32'(line_len), 32'd0);
      uart_out_valid = 1'b0;

      // Backspace / delete editing, ack ignored while collecting
      send_str("ABC");
      uart_out_valid = 1'b0;
      pulse_ack();
      chk("t2_ack_ignored_len", 32'(line_len), 32'd3);
      chk("t2_ack_ignored_valid", 32'(line_valid), 32'd0);
      send(8'h08);
      send(8'h7F);
      send_str("D");
      send(8'h0D);
      uart_out_valid = 1'b0;
      chk("t2_valid", 32'(line_valid), 32'd1);
      chk("t2_len", 32'(line_len), 32'd2);
      read_check("t2_rd0", 0, 8'h41);
      read_check("t2_rd1", 1, 8'h44);
      pulse_ack();
      send(8'h08);
      send(8'h0D);
      uart_out_valid = 1'b0;
      repeat (3) tick();
      chk("t2_empty_no_line", 32'(line_valid), 32'd0);
      chk("t2_empty_len", 32'(line_len), 32'd0);
      chk("t2_empty_ready", 32'(uart_out_ready), 32'd1);

      // Overflow: 40 'x' then LF
      for (int k = 0; k < 40; k++) send(8'h78);
      send(8'h0A);
      uart_out_valid = 1'b0;
      chk("t3_valid", 32'(line_valid), 32'd1);
      chk("t3_len", 32'(line_len), 32'd32);
      chk("t3_ovf", 32'(line_ovf), 32'd1);
      read_check("t3_rd31", 31, 8'h78);

      // Reset while holding the overflowed line
      reset_n = 1'b0;
      #1;
      chk_all_zero("t5_in_rst");
      tick();
      chk_all_zero("t5_in_rst_edge");
      reset_n = 1'b1;
      #1;
      chk("t5_ready_before_edge", 32'(uart_out_ready), 32'd0);
      tick();
      chk("t5_ready_after_edge", 32'(uart_out_ready), 32'd1);
      chk("t5_valid_after_rst", 32'(line_valid), 32'd0);
      send_str("Z");
      send(8'h0D);
      uart_out_valid = 1'b0;
      chk("t5_len", 32'(line_len), 32'd1);
      chk("t5_ovf", 32'(line_ovf), 32'd0);
      read_check("t5_rd0", 0, 8'h5A);
      pulse_ack();

      // Back-to-back "1\r" "2\r" with continuous valid and minimum turnaround
      rd_addr = 5'd0;
      send_str("1");
      send(8'h0D);
      chk("t4_valid_n1", 32'(line_valid), 32'd1);
      chk("t4_len1", 32'(line_len), 32'd1);
      chk("t4_rd_line1", 32'(rd_data), 32'h31);
      uart_out_data = 8'h32;
      pulse_ack();
      chk("t4_ready_n2", 32'(uart_out_ready), 32'd1);
      chk("t4_valid_n2", 32'(line_valid), 32'd0);
      send_byte(8'h32, w);
      chk("t4_turnaround_waits", 32'(w), 32'd0);
      send(8'h0D);
      uart_out_valid = 1'b0;
      chk("t4_valid_line2", 32'(line_valid), 32'd1);
      chk("t4_len2", 32'(line_len), 32'd1);
      chk("t4_rd_line2", 32'(rd_data), 32'h32);
      pulse_ack();

      // Random valid gaps against the reference model
      mlen = 0;
      movf = 1'b0;
      lines = 0;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) begin
            uart_out_valid = 1'b0;
            uart_out_data  = 8'($urandom);
            tick();
         end
         case ($urandom_range(0, 15))
            0:       b = 8'h0D;
            1:       b = 8'h0A;
            2:       b = 8'h08;
            3:       b = 8'h7F;
            default: b = 8'h61 + 8'($urandom_range(0, 25));
         endcase
         if ((i % 250) < 50 && (b == 8'h0D || b == 8'h0A)) b = 8'h6D;
         send_byte(b, w);
         term = 1'b0;
         if (b == 8'h0D || b == 8'h0A) begin
            if (mlen > 0 || movf) term = 1'b1;
         end else if (b == 8'h08 || b == 8'h7F) begin
            if (mlen > 0) mlen--;
         end else if (mlen < LINE_DEPTH) begin
            mbuf[mlen] = b;
            mlen++;
         end else begin
            movf = 1'b1;
         end
         if (term) begin
            uart_out_valid = 1'b0;
            lines++;
            chk("t6_valid", 32'(line_valid), 32'd1);
            chk("t6_len", 32'(line_len), 32'(mlen));
            chk("t6_ovf", 32'(line_ovf), 32'(movf));
            for (int j = 0; j < mlen; j++) read_check("t6_data", j, mbuf[j]);
            repeat ($urandom_range(0, 2)) tick();
            pulse_ack();
            mlen = 0;
            movf = 1'b0;
         end else begin
            chk("t6_no_line", 32'(line_valid), 32'd0);
            chk("t6_run_len", 32'(line_len), 32'(mlen));
         end
      end
      uart_out_valid = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_line_rx.md
SERIAL_LINE_RX -- requirements
Module: serial_line_rx

Interface
REQ-001 The block SHALL have parameter LINE_DEPTH, default 32, giving the line buffer capacity in bytes.
REQ-002 The block SHALL have port clk_48mhz, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port uart_out_data, input, 8, the received byte from the USB UART output pipeline.
REQ-005 The block SHALL have port uart_out_valid, input, 1, asserted when uart_out_data holds a byte.
REQ-006 The block SHALL have port uart_out_ready, output, 1, asserted when the block can accept a byte.
REQ-007 The block SHALL have port line_valid, output, 1, asserted while a complete line is held for the consumer.
REQ-008 The block SHALL have port line_len, output, clog2(LINE_DEPTH+1), the number of stored bytes in the held line.
REQ-009 The block SHALL have port line_ovf, output, 1, set when the held line had bytes dropped.
REQ-010 The block SHALL have port rd_addr, input, clog2(LINE_DEPTH), the line buffer read address.
REQ-011 The block SHALL have port rd_data, output, 8, the buffer byte at rd_addr.
REQ-012 The block SHALL have port line_ack, input, 1, a one-cycle pulse from the consumer releasing the held line.

Function
REQ-013 A byte SHALL be accepted only on a rising edge where uart_out_valid and uart_out_ready are both 1; uart_out_data SHALL be sampled only on that edge.
REQ-014 The block SHALL use a two-state FSM: COLLECT, where uart_out_ready=1, and HOLD, where uart_out_ready=0 and line_valid=1.
REQ-015 In COLLECT, an accepted byte other than CR (0x0D), LF (0x0A), BS (0x08) or DEL (0x7F) SHALL be written to buf[len] and len incremented when len<LINE_DEPTH; otherwise the byte SHALL be dropped and ovf set.
REQ-016 In COLLECT, an accepted BS or DEL SHALL decrement len when len>0 and be a no-op when len=0; ovf SHALL be unaffected.
REQ-017 In COLLECT, an accepted CR or LF with len>0 or ovf=1 SHALL move the FSM to HOLD, with uart_out_ready=0 and line_valid=1 from the next cycle.
REQ-018 An accepted CR or LF with len=0 and ovf=0 SHALL be discarded and the FSM SHALL stay in COLLECT, so a CRLF pair yields a single line.
REQ-019 In HOLD, line_len and line_ovf SHALL be stable and the buffer SHALL NOT be written.
REQ-020 In HOLD, line_ack=1 SHALL clear len and ovf and return the FSM to COLLECT, with line_valid=0 and uart_out_ready=1 from the next cycle.
REQ-021 line_ack SHALL be ignored in COLLECT.
REQ-022 rd_data SHALL be registered as buf[rd_addr] with one-cycle latency in either state; the content for addresses at or above line_len is undefined.
REQ-023 The minimum line turnaround SHALL be: terminator accepted in cycle N, line_valid high in N+1, line_ack in N+1, next byte accepted in N+2.

Reset
REQ-024 While reset_n=0, the FSM SHALL be in COLLECT and uart_out_ready, line_valid, line_ovf, line_len and rd_data SHALL all be 0.
REQ-025 uart_out_ready SHALL rise on the first clock edge after reset_n deasserts.
REQ-026 Buffer contents SHALL NOT be reset.
REQ-027 Reset asserted while in HOLD or mid-line SHALL discard the partial or held line.

Structure
REQ-028 The ASCII constants (CR, LF, BS, DEL) and the FSM state encoding SHALL live in shared package serial_pkg.
REQ-029 The buffer SHALL be a sub-module line_buf_ram: LINE_DEPTH x 8, one synchronous write port and one registered read port, no reset, inferable as iCE40 EBR.
REQ-030 The FSM, len and ovf logic SHALL reside in serial_line_rx.

Verification
REQ-031 The bench SHALL send "AB\r\n" with valid held high, then check line_valid, line_len=2, line_ovf=0, rd_addr 0/1 giving 0x41/0x42, exactly one line, and ready=0 until ack.
REQ-032 The bench SHALL send "ABC", 0x08, 0x7F, "D", "\r", then check line_len=2 and rd_data "A","D"; it SHALL also send 0x08 on an empty line followed by "\r" and check that no line is produced.
REQ-033 The bench SHALL send 40 x 'x' then "\n" with LINE_DEPTH=32, then check line_len=32, line_ovf=1 and that buf[31]='x'.
REQ-034 The bench SHALL drive valid continuously with back-to-back lines "1\r" and "2\r" and line_ack one cycle after line_valid, then check no byte is lost or duplicated and the REQ-023 timing.
REQ-035 The bench SHALL pulse reset_n low while in HOLD, then check that all outputs are 0 during reset, ready=1 one clock after release, and that a following "Z\r" gives line_len=1.
REQ-036 The bench SHALL toggle valid randomly across 1000 bytes against a reference model, then check all line contents and lengths match.
